// File: rtl/memory_pkg.sv
// Shared types for the memory array controller: the FSM state encoding.
package memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/memory_array_ctrl.sv
// Simple dual-port memory array with a power-up/reset clear sequence,
// registered 1-cycle read, write-first bypass and out-of-range detection.
module memory_array_ctrl
    import memory_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               ADDR_W   = 8,
    parameter int               DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err,
    output state_e            dbg_state
);

    // Handshake: requests are single-cycle strobes sampled on the rising edge;
    // there is no back-pressure, requests seen while busy=1 are discarded.

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              busy_w;
    logic              wr_in_range, rd_in_range;
    logic              wr_acc, rd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        busy_w      = (state_q == CLEAR);
        wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
        wr_acc      = wr_en && !busy_w && wr_in_range;
        rd_acc      = rd_en && !busy_w;

        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        mem_we     = wr_acc;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;

        // The clear sequence owns the single write port while it runs.
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = INIT_VAL;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
                state_d   = READY;
                clr_ptr_d = '0;
            end
        end

        rd_valid_d = rd_acc;
        addr_err_d = (rd_acc && !rd_in_range) || (wr_en && !busy_w && !wr_in_range);

        rd_data_d = rd_data_q;
        if (rd_acc) begin
            if (!rd_in_range) begin
                rd_data_d = INIT_VAL;
            end else if (wr_acc && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign busy      = busy_w;
    assign dbg_state = state_q;

endmodule
